mem_stage: RTL and testbench
============================

# mem_stage

Memory-access pipeline stage of the five-stage CPU, sitting between the execute stage and the write-back stage. It holds one instruction at a time and collects the data-SRAM read response for loads. It extends sub-word load data and drives the ms→ws valid/allowin handshake and the ms_to_ws_bus that the write-back stage consumes. It also publishes a RAW forwarding bus and a load-pending flag to the decode stage.

## Interface
- No parameters; widths are fixed (`MS_TO_WS_BUS_WD`=70, `ES_TO_MS_BUS_WD`=76, `RAW_BUS_WD`=38).
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- es_to_ms_valid  in  1  execute stage offers an instruction.
- es_to_ms_bus  in  76  fields:
  - res_from_mem [75]
  - ld_sign [74]
  - ld_size [73:72] (00 byte, 01 half, 10/11 word)
  - addr_low [71:70]
  - gr_we [69]
  - dest [68:64]
  - alu_result [63:32]
  - pc [31:0]
- ms_allowin  out  1  stage can accept an instruction this cycle.
- ws_allowin  in  1  write-back stage can accept.
- ms_to_ws_valid  out  1  instruction offered to write-back.
- ms_to_ws_bus  out  70  fields: gr_we [69], dest [68:64], final_result [63:32], pc [31:0].
- data_sram_data_ok  in  1  one-cycle pulse: read data valid for the oldest outstanding load.
- data_sram_rdata  in  32  read data, qualified by data_ok.
- raw_ms_bus  out  38  {ms_valid & gr_we [37], dest [36:32], final_result [31:0]}.
- ms_load_block  out  1  ms_valid & res_from_mem & result not yet available; decode must stall, not forward.

## Operation
- Pipeline register loads es_to_ms_bus when es_to_ms_valid & ms_allowin. ms_valid loads es_to_ms_valid whenever ms_allowin.
- Data buffer: rdata_buf (32 bits), buf_valid (1 bit).
  - data_ok while ms_valid & res_from_mem & !buf_valid & !(ms_to_ws_valid & ws_allowin): capture rdata_buf ← rdata, set buf_valid.
  - buf_valid is cleared when the instruction leaves (ms_to_ws_valid & ws_allowin).
- Effective data mem_data = buf_valid ? rdata_buf : data_sram_rdata.
- ms_ready_go = !res_from_mem | buf_valid | data_sram_data_ok.
- ms_allowin = !ms_valid | (ms_ready_go & ws_allowin).
- ms_to_ws_valid = ms_valid & ms_ready_go.
- final_result = res_from_mem ? load_ext(mem_data) : alu_result.
- load_ext:
  - byte: byte lane addr_low selects rdata[8*addr_low+7 : 8*addr_low].
  - half: addr_low[1] selects [31:16], else [15:0].
  - Sub-word results are zero-extended, or sign-extended when ld_sign=1.
  - Word: unchanged.
- States, derived from ms_valid/res_from_mem/buf_valid:
  - EMPTY → FULL_READY on accept of a non-load.
  - EMPTY → WAIT on accept of a load.
  - WAIT → FULL_READY on data_ok (buffered when ws_allowin=0).
  - Any FULL state → next instruction or EMPTY on handshake.
- data_ok while !ms_valid or while the current instruction is not a load is ignored.

## Timing
- Reset values: ms_valid=0, buf_valid=0, ms_to_ws_valid=0, ms_allowin=1, raw_ms_bus[37]=0, ms_load_block=0. Bus register contents are don't-care and gated by valid.
- Non-load: one cycle in the stage. Offered to write-back the cycle after it is accepted.
- Load: offered the cycle data_ok arrives, combinationally from data_ok to ms_to_ws_valid, ms_allowin, and final_result. Minimum one cycle.
- data_ok in the same cycle as handshake completion: data is used directly and nothing is buffered.
- Back-to-back: a new instruction may be accepted in the same cycle the current one leaves. buf_valid clears on that edge.
- Reset asserted mid-wait: the instruction is dropped and buf_valid is cleared. The next data_ok is ignored while ms_valid=0.

## Configuration
- MS_SUBWORD_LOAD_EN defined: byte/half extension as described.
- MS_SUBWORD_LOAD_EN undefined: final_result for loads is mem_data unchanged. ld_sign, ld_size and addr_low are ignored; the bus layout is unchanged.

## Test plan
- Non-load, alu_result=0x1234_5678, dest=5, gr_we=1, ws_allowin=1 -> next cycle ms_to_ws_valid=1, bus={1,5,0x12345678,pc}, raw_ms_bus[37]=1.
- Load word, data_ok two cycles after accept with rdata=0xDEAD_BEEF -> ms_load_block=1 for two cycles. ms_to_ws_valid rises in the data_ok cycle with final_result=0xDEADBEEF.
- Signed byte, addr_low=3, rdata=0x80FF_0000 -> final_result=0xFFFF_FF80. Same access unsigned -> 0x0000_0080 (with MS_SUBWORD_LOAD_EN).
- Load with ws_allowin=0 when data_ok pulses, rdata=0xA5A5_0001, then rdata changes -> buf_valid=1. When ws_allowin rises, the stage hands off 0xA5A50001 and then buf_valid=0.
- reset=1 for one cycle while waiting for a load -> ms_valid=0 and ms_allowin=1 the next cycle. A later stray data_ok produces no ms_to_ws_valid.

Source files
------------

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: holds one instruction, collects the data-SRAM
// read response for loads, and feeds write-back. Sub-word load extension is
// built only when MS_SUBWORD_LOAD_EN is defined.
module mem_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        es_to_ms_valid,
  input  logic [75:0] es_to_ms_bus,
  output logic        ms_allowin,
  input  logic        ws_allowin,
  output logic        ms_to_ws_valid,
  output logic [69:0] ms_to_ws_bus,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata,
  output logic [37:0] raw_ms_bus,
  output logic        ms_load_block
);

  localparam int MS_TO_WS_BUS_WD = 70;
  localparam int ES_TO_MS_BUS_WD = 76;
  localparam int RAW_BUS_WD      = 38;

  logic                       ms_valid_q,  ms_valid_d;
  logic [ES_TO_MS_BUS_WD-1:0] bus_q,       bus_d;
  logic                       buf_valid_q, buf_valid_d;
  logic [31:0]                rdata_buf_q, rdata_buf_d;

  logic        res_from_mem_s;
  logic        ld_sign_s;
  logic [1:0]  ld_size_s;
  logic [1:0]  addr_low_s;
  logic        gr_we_s;
  logic [4:0]  dest_s;
  logic [31:0] alu_result_s;
  logic [31:0] pc_s;
  logic [31:0] mem_data_s;
  logic [31:0] final_result_s;
  logic        ms_ready_go_s;
  logic        handshake_s;

  assign res_from_mem_s = bus_q[75];
  assign ld_sign_s      = bus_q[74];
  assign ld_size_s      = bus_q[73:72];
  assign addr_low_s     = bus_q[71:70];
  assign gr_we_s        = bus_q[69];
  assign dest_s         = bus_q[68:64];
  assign alu_result_s   = bus_q[63:32];
  assign pc_s           = bus_q[31:0];

`ifdef MS_SUBWORD_LOAD_EN
  function automatic logic [31:0] load_ext(input logic [31:0] data,
                                           input logic [1:0]  size,
                                           input logic [1:0]  lane,
                                           input logic        sign);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lane)
      2'b00:   b = data[7:0];
      2'b01:   b = data[15:8];
      2'b10:   b = data[23:16];
      default: b = data[31:24];
    endcase
    h = lane[1] ? data[31:16] : data[15:0];
    case (size)
      2'b00:   r = {{24{sign & b[7]}}, b};
      2'b01:   r = {{16{sign & h[15]}}, h};
      default: r = data;
    endcase
    return r;
  endfunction
`else
  logic unused_ok_s;
  assign unused_ok_s = ^{ld_sign_s, ld_size_s, addr_low_s};
`endif

  // Handshake, result selection and decode-side bypass/stall outputs.
  always_comb begin
    mem_data_s     = buf_valid_q ? rdata_buf_q : data_sram_rdata;
    ms_ready_go_s  = !res_from_mem_s | buf_valid_q | data_sram_data_ok;
    ms_allowin     = !ms_valid_q | (ms_ready_go_s & ws_allowin);
    ms_to_ws_valid = ms_valid_q & ms_ready_go_s;
    handshake_s    = ms_to_ws_valid & ws_allowin;
    if (res_from_mem_s) begin
`ifdef MS_SUBWORD_LOAD_EN
      final_result_s = load_ext(mem_data_s, ld_size_s, addr_low_s, ld_sign_s);
`else
      final_result_s = mem_data_s;
`endif
    end else begin
      final_result_s = alu_result_s;
    end
    ms_to_ws_bus  = {gr_we_s, dest_s, final_result_s, pc_s};
    raw_ms_bus    = {ms_valid_q & gr_we_s, dest_s, final_result_s};
    ms_load_block = ms_valid_q & res_from_mem_s & !buf_valid_q & !data_sram_data_ok;
  end

  // Next state: a response is buffered only if it cannot be consumed this cycle.
  always_comb begin
    ms_valid_d  = ms_valid_q;
    bus_d       = bus_q;
    buf_valid_d = buf_valid_q;
    rdata_buf_d = rdata_buf_q;
    if (ms_allowin) begin
      ms_valid_d = es_to_ms_valid;
    end else begin
      ms_valid_d = ms_valid_q;
    end
    if (es_to_ms_valid & ms_allowin) begin
      bus_d = es_to_ms_bus;
    end else begin
      bus_d = bus_q;
    end
    if (handshake_s) begin
      buf_valid_d = 1'b0;
    end else if (data_sram_data_ok & ms_valid_q & res_from_mem_s & !buf_valid_q) begin
      buf_valid_d = 1'b1;
      rdata_buf_d = data_sram_rdata;
    end else begin
      buf_valid_d = buf_valid_q;
    end
  end

  // Stage state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid_q  <= 1'b0;
      bus_q       <= {ES_TO_MS_BUS_WD{1'b0}};
      buf_valid_q <= 1'b0;
      rdata_buf_q <= 32'h0000_0000;
    end else begin
      ms_valid_q  <= ms_valid_d;
      bus_q       <= bus_d;
      buf_valid_q <= buf_valid_d;
      rdata_buf_q <= rdata_buf_d;
    end
  end

  // Compile-time consistency of the published bus widths.
  if ((MS_TO_WS_BUS_WD != 70) || (RAW_BUS_WD != 38)) begin : g_width_guard
    $error("mem_stage bus width mismatch");
  end

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: directed test-plan steps followed by random traffic,
// checked every cycle against a slot-level reference model.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        es_to_ms_valid;
  logic [75:0] es_to_ms_bus;
  logic        ms_allowin;
  logic        ws_allowin;
  logic        ms_to_ws_valid;
  logic [69:0] ms_to_ws_bus;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic [37:0] raw_ms_bus;
  logic        ms_load_block;

  int checks = 0;
  int errors = 0;

  // Reference model: the one-instruction slot and any captured load data.
  bit          m_full;
  logic [75:0] m_ins;
  bit          m_have_data;
  logic [31:0] m_data;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .reset(reset),
    .es_to_ms_valid(es_to_ms_valid), .es_to_ms_bus(es_to_ms_bus),
    .ms_allowin(ms_allowin), .ws_allowin(ws_allowin),
    .ms_to_ws_valid(ms_to_ws_valid), .ms_to_ws_bus(ms_to_ws_bus),
    .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
    .raw_ms_bus(raw_ms_bus), .ms_load_block(ms_load_block)
  );

  function automatic logic [75:0] mk(bit rfm, bit sgn, int sz, int lo, bit we,
                                     int dst, logic [31:0] alu, logic [31:0] pc);
    logic [75:0] b;
    b = {rfm, sgn, 2'(sz), 2'(lo), we, 5'(dst), alu, pc};
    return b;
  endfunction

  function automatic logic [31:0] ref_load(logic [75:0] ins, logic [31:0] d);
`ifdef MS_SUBWORD_LOAD_EN
    int unsigned sz;
    int unsigned lo;
    logic [31:0] v;
    sz = ins[73:72];
    lo = ins[71:70];
    if (sz == 0) begin
      v = (d >> (8 * lo)) & 32'h0000_00FF;
      if (ins[74] && v[7]) v = v | 32'hFFFF_FF00;
    end else if (sz == 1) begin
      v = (d >> (16 * (lo / 2))) & 32'h0000_FFFF;
      if (ins[74] && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = d;
    end
    return v;
`else
    return d;
`endif
  endfunction

  task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(bit rst, bit esv, logic [75:0] bus, bit wsa, bit dok, logic [31:0] rd);
    @(negedge clk);
    reset             = rst;
    es_to_ms_valid    = esv;
    es_to_ms_bus      = bus;
    ws_allowin        = wsa;
    data_sram_data_ok = dok;
    data_sram_rdata   = rd;
    #1;
  endtask

  // Compare this cycle's outputs with the model, then advance across the edge.
  task automatic tick();
    bit          ready;
    bit          leaves;
    bit          takes;
    logic [31:0] res;
    ready  = m_full && (!m_ins[75] || m_have_data || data_sram_data_ok);
    res    = m_ins[75] ? ref_load(m_ins, m_have_data ? m_data : data_sram_rdata) : m_ins[63:32];
    leaves = ready && ws_allowin;
    takes  = !m_full || leaves;
    chk("ms_to_ws_valid", 70'(ms_to_ws_valid), 70'(ready));
    chk("ms_allowin", 70'(ms_allowin), 70'(takes));
    chk("ms_load_block", 70'(ms_load_block), 70'(m_full && m_ins[75] && !ready));
    chk("raw_we", 70'(raw_ms_bus[37]), 70'(m_full && m_ins[69]));
    if (ready) begin
      chk("ms_to_ws_bus", ms_to_ws_bus, {m_ins[69], m_ins[68:64], res, m_ins[31:0]});
      chk("raw_data", 70'(raw_ms_bus[36:0]), 70'({m_ins[68:64], res}));
    end
    @(posedge clk);
    if (reset) begin
      m_full      = 1'b0;
      m_have_data = 1'b0;
    end else begin
      if (leaves) begin
        m_have_data = 1'b0;
      end else if (m_full && m_ins[75] && !m_have_data && data_sram_data_ok) begin
        m_have_data = 1'b1;
        m_data      = data_sram_rdata;
      end
      if (takes) begin
        m_full = es_to_ms_valid;
        if (es_to_ms_valid) m_ins = es_to_ms_bus;
      end
    end
  endtask

  task automatic step(bit rst, bit esv, logic [75:0] bus, bit wsa, bit dok, logic [31:0] rd);
    drive(rst, esv, bus, wsa, dok, rd);
    tick();
  endtask

  initial begin
    logic [75:0] ld;
    logic [95:0] rnd;
    m_full      = 1'b0;
    m_have_data = 1'b0;
    m_ins       = 76'h0;
    m_data      = 32'h0;
    drive(1'b1, 1'b0, 76'h0, 1'b1, 1'b0, 32'h0);
    repeat (2) @(posedge clk);
    drive(1'b0, 1'b0, 76'h0, 1'b1, 1'b0, 32'h0);
    chk("reset_valid", 70'(ms_to_ws_valid), 70'd0);
    chk("reset_allowin", 70'(ms_allowin), 70'd1);
    chk("reset_raw_we", 70'(raw_ms_bus[37]), 70'd0);
    chk("reset_block", 70'(ms_load_block), 70'd0);
    tick();

    // Non-load passes through in one cycle.
    step(1'b0, 1'b1, mk(0, 0, 2, 0, 1, 5, 32'h1234_5678, 32'h0000_0100), 1'b1, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 76'h0, 1'b1, 1'b0, 32'h0);
    chk("nl_valid", 70'(ms_to_ws_valid), 70'd1);
    chk("nl_bus", ms_to_ws_bus, {1'b1, 5'd5, 32'h1234_5678, 32'h0000_0100});
    chk("nl_raw_we", 70'(raw_ms_bus[37]), 70'd1);
    tick();

    // Word load, data two cycles later.
    step(1'b0, 1'b1, mk(1, 0, 2, 0, 1, 7, 32'h0000_0040, 32'h0000_0104), 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0, 76'h0, 1'b1, 1'b0, 32'h0);
      chk("lw_block", 70'(ms_load_block), 70'd1);
      chk("lw_wait_valid", 70'(ms_to_ws_valid), 70'd0);
      tick();
    end
    drive(1'b0, 1'b0, 76'h0, 1'b1, 1'b1, 32'hDEAD_BEEF);
    chk("lw_valid", 70'(ms_to_ws_valid), 70'd1);
    chk("lw_result", 70'(ms_to_ws_bus[63:32]), 70'(32'hDEAD_BEEF));
    tick();

    // Signed then unsigned byte from lane 3.
    for (int s = 1; s >= 0; s--) begin
      step(1'b0, 1'b1, mk(1, s[0], 0, 3, 1, 9, 32'h0000_0043, 32'h0000_0108), 1'b1, 1'b0, 32'h0);
      drive(1'b0, 1'b0, 76'h0, 1'b1, 1'b1, 32'h80FF_0000);
`ifdef MS_SUBWORD_LOAD_EN
      chk("lb_result", 70'(ms_to_ws_bus[63:32]), 70'((s == 1) ? 32'hFFFF_FF80 : 32'h0000_0080));
`else
      chk("lb_result", 70'(ms_to_ws_bus[63:32]), 70'(32'h80FF_0000));
`endif
      tick();
    end

    // Response arrives while write-back is stalled and must be buffered.
    ld = mk(1, 0, 2, 0, 1, 3, 32'h0000_0080, 32'h0000_010C);
    step(1'b0, 1'b1, ld, 1'b1, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 76'h0, 1'b0, 1'b1, 32'hA5A5_0001);
    chk("buf_allowin", 70'(ms_allowin), 70'd0);
    tick();
    drive(1'b0, 1'b0, 76'h0, 1'b0, 1'b0, 32'h1111_2222);
    chk("buf_hold", 70'(ms_to_ws_bus[63:32]), 70'(32'hA5A5_0001));
    chk("buf_block", 70'(ms_load_block), 70'd0);
    tick();
    drive(1'b0, 1'b0, 76'h0, 1'b1, 1'b0, 32'h3333_4444);
    chk("buf_handoff", 70'(ms_to_ws_bus[63:32]), 70'(32'hA5A5_0001));
    tick();
    step(1'b0, 1'b1, ld, 1'b1, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 76'h0, 1'b1, 1'b0, 32'h5555_6666);
    chk("buf_cleared", 70'(ms_load_block), 70'd1);
    tick();
    step(1'b0, 1'b0, 76'h0, 1'b1, 1'b1, 32'h7777_8888);

    // Reset while a load waits; a later stray response is ignored.
    step(1'b0, 1'b1, ld, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 76'h0, 1'b1, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 76'h0, 1'b1, 1'b0, 32'h0);
    chk("rst_valid", 70'(ms_to_ws_valid), 70'd0);
    chk("rst_allowin", 70'(ms_allowin), 70'd1);
    tick();
    drive(1'b0, 1'b0, 76'h0, 1'b1, 1'b1, 32'h9999_AAAA);
    chk("stray_valid", 70'(ms_to_ws_valid), 70'd0);
    tick();

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      rnd = {$urandom(), $urandom(), $urandom()};
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) != 0), rnd[75:0],
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) < 3), $urandom());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
